// File: rtl/qs_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qs_cmd_pkg
//  Purpose  : Shared constants for the SPI command decoder: opcodes, frame
//             field positions, status-word constants and a status-word builder.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package qs_cmd_pkg;

    // Opcodes carried in the frame's top nibble; anything above OP_STOP is invalid
    localparam logic [3:0] OP_NOP         = 4'd0;
    localparam logic [3:0] OP_SET_PERIOD  = 4'd1;
    localparam logic [3:0] OP_SET_STEPS   = 4'd2;
    localparam logic [3:0] OP_SET_ENABLE  = 4'd3;
    localparam logic [3:0] OP_READ_POS    = 4'd4;
    localparam logic [3:0] OP_READ_STATUS = 4'd5;
    localparam logic [3:0] OP_STOP        = 4'd6;

    // Frame field bit positions
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 28;
    localparam int AXIS_HI  = 27;
    localparam int AXIS_LO  = 26;
    localparam int RSVD_BIT = 25;
    localparam int PAR_BIT  = 24;
    localparam int DATA_LO  = 0;

    // Status-word identification byte
    localparam logic [7:0] MAGIC = 8'hA5;

    // Response words for rejected frames
    localparam logic [31:0] ERR_WORD     = 32'hFFFF_FFFF;
    localparam logic [31:0] PAR_ERR_WORD = 32'hFFFF_FFFE;

    // Status word layout: [31:24] magic, [23:16] err_cnt, [15:8] frame_cnt,
    // [7:4] busy flags, [3:0] enables
    function automatic logic [31:0] status_word(
        input logic [7:0] magic,
        input logic [7:0] err_cnt,
        input logic [7:0] frame_cnt,
        input logic [3:0] busy,
        input logic [3:0] enable
    );
        return {magic, err_cnt, frame_cnt, busy, enable};
    endfunction

endpackage : qs_cmd_pkg
`default_nettype wire

// File: rtl/qs_axis_regs.sv
`default_nettype none
// ============================================================================
//  Module   : qs_axis_regs
//  Purpose  : Period / step-count registers and one-cycle load / stop strobes
//             for a single stepper axis.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             data                - payload of the decoded frame
//             set_period          - write period register this cycle
//             set_steps           - write steps register and strobe load
//             stop                - strobe stop
//             period, steps       - registered axis configuration
//             load_pulse          - one-cycle strobe after a steps write
//             stop_pulse          - one-cycle strobe after a stop command
//  Revision : 1.0 - initial release
// ============================================================================
module qs_axis_regs
    import qs_cmd_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              set_period,
    input  logic              set_steps,
    input  logic              stop,
    output logic [DATA_W-1:0] period,
    output logic [DATA_W-1:0] steps,
    output logic              load_pulse,
    output logic              stop_pulse
);

    logic [DATA_W-1:0] r_period;
    logic [DATA_W-1:0] r_steps;
    logic              r_load;
    logic              r_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_steps  <= '0;
            r_load   <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            // Strobes follow their request by one edge and drop the next cycle
            r_load <= set_steps;
            r_stop <= stop;
            if (set_period) begin
                r_period <= data;
            end
            if (set_steps) begin
                r_steps <= data;
            end
        end
    end

    assign period     = r_period;
    assign steps      = r_steps;
    assign load_pulse = r_load;
    assign stop_pulse = r_stop;

endmodule : qs_axis_regs
`default_nettype wire

// File: rtl/qs_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : qs_cmd_decoder
//  Purpose  : Decodes completed 32-bit SPI frames into per-axis stepper
//             registers and command strobes, and prepares the response word
//             shifted out during the next frame.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             rx_data, rx_ready   - completed frame and its level-valid flag
//             tx_data             - response word for the next frame
//             pos_in, busy_in     - per-axis position and motion-active flags
//             period_out          - per-axis step period
//             steps_out           - per-axis move length
//             enable_out          - per-axis driver enable
//             load_pulse          - one-cycle move-start strobe per axis
//             stop_pulse          - one-cycle abort strobe per axis
//             err_cnt             - saturating rejected-frame count
//  Options  : QS_CMD_PARITY_EN    - check even parity over the whole frame
//  Revision : 1.0 - initial release
// ============================================================================
module qs_cmd_decoder #(
    parameter int         NUM_AXES = 4,
    parameter int         DATA_W   = 24,
    parameter logic [7:0] MAGIC    = qs_cmd_pkg::MAGIC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                rx_data,
    input  logic                       rx_ready,
    output logic [31:0]                tx_data,
    input  logic [127:0]               pos_in,
    input  logic [3:0]                 busy_in,
    output logic [NUM_AXES*DATA_W-1:0] period_out,
    output logic [NUM_AXES*DATA_W-1:0] steps_out,
    output logic [3:0]                 enable_out,
    output logic [NUM_AXES-1:0]        load_pulse,
    output logic [NUM_AXES-1:0]        stop_pulse,
    output logic [7:0]                 err_cnt
);

    import qs_cmd_pkg::*;

    logic              r_rdy_d;
    logic [7:0]        r_frame_cnt;
    logic [7:0]        r_err_cnt;
    logic [3:0]        r_enable;
    logic [31:0]       r_tx;

    logic              w_accept;
    logic [3:0]        w_op;
    logic [1:0]        w_axis;
    logic [DATA_W-1:0] w_data;
    logic              w_par_ok;
    logic              w_op_valid;
    logic              w_cmd;
    logic [31:0]       w_pos_sel;
    logic              w_unused_rsvd;

    // rx_ready is a level held for the rest of the cs-low period, so only its
    // rising edge starts a decode. r_rdy_d resets high so a frame already
    // complete at reset release is ignored.
    assign w_accept = rx_ready & ~r_rdy_d;

    assign w_op   = rx_data[OPC_HI:OPC_LO];
    assign w_axis = rx_data[AXIS_HI:AXIS_LO];
    assign w_data = rx_data[DATA_LO +: DATA_W];

    // Reserved bits are intentionally not decoded
    assign w_unused_rsvd = ^rx_data[RSVD_BIT:PAR_BIT];

`ifdef QS_CMD_PARITY_EN
    // Even parity: the XOR of all 32 frame bits, parity bit included, is zero
    assign w_par_ok = ~(^rx_data);
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_op_valid = (w_op <= OP_STOP);
    assign w_cmd      = w_accept & w_par_ok & w_op_valid;

    // Position word of the addressed axis, sampled in the accept cycle
    assign w_pos_sel = pos_in[{w_axis, 5'b00000} +: 32];

    generate
        for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
            logic w_hit;
            assign w_hit = w_cmd & (w_axis == 2'(a));

            qs_axis_regs #(
                .DATA_W (DATA_W)
            ) u_axis_regs (
                .clk        (clk),
                .rst_n      (rst_n),
                .data       (w_data),
                .set_period (w_hit & (w_op == OP_SET_PERIOD)),
                .set_steps  (w_hit & (w_op == OP_SET_STEPS)),
                .stop       (w_hit & (w_op == OP_STOP)),
                .period     (period_out[a*DATA_W +: DATA_W]),
                .steps      (steps_out[a*DATA_W +: DATA_W]),
                .load_pulse (load_pulse[a]),
                .stop_pulse (stop_pulse[a])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_d     <= 1'b1;
            r_frame_cnt <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_enable    <= 4'd0;
            r_tx        <= 32'd0;
        end else begin
            r_rdy_d <= rx_ready;
            if (w_accept) begin
                // Every accepted frame counts, rejected ones included
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (!w_par_ok) begin
                    r_tx <= PAR_ERR_WORD;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end else if (!w_op_valid) begin
                    r_tx <= ERR_WORD;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end else begin
                    case (w_op)
                        OP_READ_POS: begin
                            r_tx <= w_pos_sel;
                        end
                        OP_READ_STATUS: begin
                            // Reports counters as they stood before this frame
                            r_tx <= status_word(MAGIC, r_err_cnt, r_frame_cnt,
                                                busy_in, r_enable);
                        end
                        OP_SET_ENABLE: begin
                            r_enable <= rx_data[3:0];
                            r_tx     <= rx_data;
                        end
                        default: begin
                            // Write and strobe commands acknowledge by echo
                            r_tx <= rx_data;
                        end
                    endcase
                end
            end
        end
    end

    assign tx_data    = r_tx;
    assign enable_out = r_enable;
    assign err_cnt    = r_err_cnt;

endmodule : qs_cmd_decoder
`default_nettype wire

// File: tb/tb_qs_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qs_cmd_decoder
//  Purpose  : Self-checking bench for qs_cmd_decoder. A small reference model
//             predicts every response; expected tx words are queued when a
//             frame is driven and compared once the DUT has updated.
//  Options  : QS_CMD_PARITY_EN    - also exercises the parity-reject path
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qs_cmd_decoder;

    logic         clk;
    logic         rst_n;
    logic [31:0]  rx_data;
    logic         rx_ready;
    logic [31:0]  tx_data;
    logic [127:0] pos_in;
    logic [3:0]   busy_in;
    logic [95:0]  period_out;
    logic [95:0]  steps_out;
    logic [3:0]   enable_out;
    logic [3:0]   load_pulse;
    logic [3:0]   stop_pulse;
    logic [7:0]   err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [23:0] m_period [4];
    logic [23:0] m_steps  [4];
    logic [3:0]  m_enable;
    logic [7:0]  m_frame;
    logic [7:0]  m_err;
    logic [31:0] sb_q [$];

    qs_cmd_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .pos_in     (pos_in),
        .busy_in    (busy_in),
        .period_out (period_out),
        .steps_out  (steps_out),
        .enable_out (enable_out),
        .load_pulse (load_pulse),
        .stop_pulse (stop_pulse),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] ax,
                                       input logic [23:0] data);
        logic [31:0] w;
        w     = {op, ax, 1'b0, 1'b0, data};
        w[24] = ^w;  // even parity over the whole frame
        return w;
    endfunction

    function automatic logic [95:0] pack_period();
        return {m_period[3], m_period[2], m_period[1], m_period[0]};
    endfunction

    function automatic logic [95:0] pack_steps();
        return {m_steps[3], m_steps[2], m_steps[1], m_steps[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_period[i] = '0;
            m_steps[i]  = '0;
        end
        m_enable = '0;
        m_frame  = '0;
        m_err    = '0;
    endtask

    // Drive one frame for 'hold' cycles (hold >= 2) and check the outcome
    task automatic send(input logic [31:0] w, input int hold);
        logic [3:0]  op;
        int          ax;
        logic        bad_par;
        logic [31:0] e_tx;
        logic [3:0]  e_load;
        logic [3:0]  e_stop;
        @(negedge clk);
        rx_data  = w;
        rx_ready = 1'b1;
        op       = w[31:28];
        ax       = int'(w[27:26]);
`ifdef QS_CMD_PARITY_EN
        bad_par  = ^w;
`else
        bad_par  = 1'b0;
`endif
        e_load = '0;
        e_stop = '0;
        if (bad_par) begin
            e_tx = 32'hFFFF_FFFE;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end else if (op > 4'd6) begin
            e_tx = 32'hFFFF_FFFF;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end else begin
            e_tx = w;
            case (op)
                4'd1: m_period[ax] = w[23:0];
                4'd2: begin m_steps[ax] = w[23:0]; e_load[ax] = 1'b1; end
                4'd3: m_enable = w[3:0];
                4'd4: e_tx = pos_in[ax*32 +: 32];
                4'd5: e_tx = {8'hA5, m_err, m_frame, busy_in, m_enable};
                4'd6: e_stop[ax] = 1'b1;
                default: ;
            endcase
        end
        m_frame = m_frame + 8'd1;
        sb_q.push_back(e_tx);

        @(negedge clk);
        chk("tx_data",    tx_data,    sb_q.pop_front());
        chk("period_out", period_out, pack_period());
        chk("steps_out",  steps_out,  pack_steps());
        chk("enable_out", enable_out, m_enable);
        chk("err_cnt",    err_cnt,    m_err);
        chk("load_pulse", load_pulse, e_load);
        chk("stop_pulse", stop_pulse, e_stop);

        repeat (hold - 1) @(negedge clk);
        chk("load_pulse_end", load_pulse, 4'b0000);
        chk("stop_pulse_end", stop_pulse, 4'b0000);
        chk("period_hold",    period_out, pack_period());
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rst_n    = 1'b0;
        rx_ready = 1'b1;
        rx_data  = mk(4'd1, 2'd0, 24'h000123);
        pos_in   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        busy_in  = 4'b0000;

        // Reset release with a frame already complete: must be ignored
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_period",  period_out, 96'd0);
        chk("rst_tx",      tx_data,    32'd0);
        chk("rst_enable",  enable_out, 4'd0);
        chk("rst_err",     err_cnt,    8'd0);
        chk("rst_load",    load_pulse, 4'd0);
        rx_ready = 1'b0;
        @(negedge clk);

        // Held rx_ready must decode once only (checked via frame_cnt later)
        send(mk(4'd1, 2'd2, 24'h000400), 20);
        send(mk(4'd2, 2'd1, 24'd1000), 3);
        send(mk(4'd3, 2'd0, 24'h000005), 3);
        busy_in = 4'b1010;
        send(mk(4'd5, 2'd0, 24'h0), 3);
        send(mk(4'd6, 2'd3, 24'h0), 3);
        pos_in[127:96] = 32'hDEAD_BEEF;
        send(mk(4'd4, 2'd3, 24'h0), 3);
        send(mk(4'd0, 2'd1, 24'h123456), 2);

        // Invalid opcodes: err_cnt saturates, frame_cnt wraps
        for (int i = 0; i < 256; i++) begin
            send(mk(4'd9, 2'(i), 24'(i)), 2);
        end
        chk("err_saturated", err_cnt, 8'hFF);
        send(mk(4'd5, 2'd0, 24'h0), 3);

`ifdef QS_CMD_PARITY_EN
        send(mk(4'd3, 2'd0, 24'h00000F) ^ 32'h0100_0000, 3);
        chk("par_enable_kept", enable_out, 4'h5);
        send(mk(4'd3, 2'd0, 24'h00000F), 3);
        chk("par_enable_set", enable_out, 4'hF);
`endif

        // Asynchronous reset mid-frame clears everything at once
        @(negedge clk);
        rx_data  = mk(4'd1, 2'd1, 24'h000ABC);
        rx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_period", period_out, 96'd0);
        chk("arst_steps",  steps_out,  96'd0);
        chk("arst_tx",     tx_data,    32'd0);
        chk("arst_err",    err_cnt,    8'd0);
        chk("arst_enable", enable_out, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_discard", period_out, 96'd0);
        rx_ready = 1'b0;
        @(negedge clk);
        send(mk(4'd5, 2'd0, 24'h0), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_qs_cmd_decoder
`default_nettype wire
